tmds_channel_decoder: RTL and testbench

- Receive-side counterpart of the DVI/TMDS output path; one instance per TMDS channel (blue, green, red).
- Takes 10-bit parallel words from the channel deserializer, once per pixel clock.
- Finds the 10-bit word boundary by detecting control tokens and pulsing a bitslip request back to the deserializer.
- Once aligned, decodes each word into 8-bit pixel data, or into the two control bits and a data-enable flag.

---
 rtl/tmds_channel_decoder.sv | 195 +++++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word-boundary alignment on control tokens plus
// per-word decode into pixel data or control bits. One instance per channel.
module tmds_channel_decoder #(
    parameter int CTRL_RUN       = 16,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SETTLE_CYCLES  = 8,
    parameter int LOSS_TIMEOUT   = 8192
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic [9:0] tmds_word,
    output logic       bitslip,
    output logic       aligned,
    output logic [3:0] slip_count,
    output logic [7:0] data,
    output logic       c0,
    output logic       c1,
    output logic       de
);

    localparam int SW = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int TW = $clog2(SETTLE_CYCLES) + 1;
    localparam int RW = $clog2(CTRL_RUN) + 1;
    localparam int LW = $clog2(LOSS_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // Returns {is_token, c1, c0} for the four control tokens.
    function automatic logic [2:0] token_lookup(input logic [9:0] w);
        logic [2:0] r;
        case (w)
            10'b1101010100: r = 3'b100;
            10'b0010101011: r = 3'b101;
            10'b0101010100: r = 3'b110;
            10'b1010101011: r = 3'b111;
            default:        r = 3'b000;
        endcase
        return r;
    endfunction

    // Undo the optional inversion (q[9]) and the XOR/XNOR chain (q[8]).
    function automatic logic [7:0] tmds_data_decode(input logic [9:0] q);
        logic [7:0] v;
        logic [7:0] d;
        v    = q[9] ? ~q[7:0] : q[7:0];
        d[0] = v[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        end
        return d;
    endfunction

    logic [2:0]    tok_s;
    logic          tok_valid_s;

    state_t        state_r, state_s;
    logic [SW-1:0] search_cnt_r, search_cnt_s;
    logic [TW-1:0] settle_cnt_r, settle_cnt_s;
    logic [RW-1:0] run_cnt_r, run_cnt_s;
    logic [LW-1:0] loss_cnt_r, loss_cnt_s;
    logic          bitslip_r, bitslip_s;
    logic          aligned_r, aligned_s;
    logic [3:0]    slip_count_r, slip_count_s;

    logic [7:0]    data_r;
    logic          c0_r, c1_r, de_r;

    assign tok_s       = token_lookup(tmds_word);
    assign tok_valid_s = tok_s[2];

    // Alignment FSM: next state, counters and the registered status outputs.
    always_comb begin
        state_s      = state_r;
        search_cnt_s = search_cnt_r;
        settle_cnt_s = settle_cnt_r;
        run_cnt_s    = run_cnt_r;
        loss_cnt_s   = loss_cnt_r;
        bitslip_s    = 1'b0;
        aligned_s    = 1'b0;
        slip_count_s = slip_count_r;
        case (state_r)
            ST_SEARCH: begin
                // A token on the timeout cycle takes priority over slipping.
                if (tok_valid_s) begin
                    state_s      = ST_CHECK;
                    run_cnt_s    = RW'(1);
                    search_cnt_s = '0;
                end else if (search_cnt_r == SW'(SEARCH_TIMEOUT - 1)) begin
                    state_s      = ST_SETTLE;
                    bitslip_s    = 1'b1;
                    settle_cnt_s = '0;
                    search_cnt_s = '0;
                    slip_count_s = (slip_count_r == 4'd9) ? 4'd0 : slip_count_r + 4'd1;
                end else begin
                    search_cnt_s = search_cnt_r + SW'(1);
                end
            end
            ST_SETTLE: begin
                // Deserializer output is unreliable right after a slip.
                if (settle_cnt_r == TW'(SETTLE_CYCLES - 1)) begin
                    state_s      = ST_SEARCH;
                    search_cnt_s = '0;
                end else begin
                    settle_cnt_s = settle_cnt_r + TW'(1);
                end
            end
            ST_CHECK: begin
                if (tok_valid_s) begin
                    if (run_cnt_r == RW'(CTRL_RUN - 1)) begin
                        state_s    = ST_LOCKED;
                        aligned_s  = 1'b1;
                        loss_cnt_s = '0;
                    end else begin
                        run_cnt_s = run_cnt_r + RW'(1);
                    end
                end else begin
                    // Short blanking run: retry later without slipping.
                    state_s      = ST_SEARCH;
                    search_cnt_s = '0;
                end
            end
            ST_LOCKED: begin
                aligned_s = 1'b1;
                if (tok_valid_s) begin
                    loss_cnt_s = '0;
                end else if (loss_cnt_r == LW'(LOSS_TIMEOUT - 1)) begin
                    state_s      = ST_SEARCH;
                    aligned_s    = 1'b0;
                    search_cnt_s = '0;
                end else begin
                    loss_cnt_s = loss_cnt_r + LW'(1);
                end
            end
            default: begin
                state_s      = ST_SEARCH;
                search_cnt_s = '0;
            end
        endcase
    end

    // FSM state, counters and status output registers.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_SEARCH;
            search_cnt_r <= '0;
            settle_cnt_r <= '0;
            run_cnt_r    <= '0;
            loss_cnt_r   <= '0;
            bitslip_r    <= 1'b0;
            aligned_r    <= 1'b0;
            slip_count_r <= 4'd0;
        end else begin
            state_r      <= state_s;
            search_cnt_r <= search_cnt_s;
            settle_cnt_r <= settle_cnt_s;
            run_cnt_r    <= run_cnt_s;
            loss_cnt_r   <= loss_cnt_s;
            bitslip_r    <= bitslip_s;
            aligned_r    <= aligned_s;
            slip_count_r <= slip_count_s;
        end
    end

    // Word decode, one cycle of latency, independent of alignment state.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            data_r <= 8'd0;
            c0_r   <= 1'b0;
            c1_r   <= 1'b0;
            de_r   <= 1'b0;
        end else if (tok_valid_s) begin
            data_r <= 8'd0;
            c1_r   <= tok_s[1];
            c0_r   <= tok_s[0];
            de_r   <= 1'b0;
        end else begin
            data_r <= tmds_data_decode(tmds_word);
            de_r   <= 1'b1;
        end
    end

    assign bitslip    = bitslip_r;
    assign aligned    = aligned_r;
    assign slip_count = slip_count_r;
    assign data       = data_r;
    assign c0         = c0_r;
    assign c1         = c1_r;
    assign de         = de_r;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: decode scoreboard, alignment,
// slip timing/wrap, lock loss and asynchronous reset.
module tb_tmds_channel_decoder;

    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    localparam logic [9:0] TOK10 = 10'b0101010100;
    localparam logic [9:0] TOK11 = 10'b1010101011;
    localparam logic [9:0] DATA0 = 10'b0100000000;

    logic       clk_pixel = 1'b0;
    logic       reset_n;
    logic [9:0] tmds_word;
    logic       bitslip;
    logic       aligned;
    logic [3:0] slip_count;
    logic [7:0] data;
    logic       c0;
    logic       c1;
    logic       de;

    int n_tests = 0;
    int n_fail  = 0;
    int slip_seen = 0;
    int enc_cnt = 0;
    logic [10:0] sb_q[$];

    tmds_channel_decoder dut (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .tmds_word (tmds_word),
        .bitslip   (bitslip),
        .aligned   (aligned),
        .slip_count(slip_count),
        .data      (data),
        .c0        (c0),
        .c1        (c1),
        .de        (de)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Count cycles in which bitslip is high, sampled mid-cycle.
    always @(negedge clk_pixel) begin
        if (bitslip === 1'b1) slip_seen <= slip_seen + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic put(input logic [9:0] w);
        tmds_word = w;
        tick();
    endtask

    // Scoreboard step: expected {de,c1,c0,data} is queued with the word and
    // checked once the decoder has registered it.
    task automatic drive_exp(input string tag, input logic [9:0] w, input logic [7:0] ed,
                             input logic ec1, input logic ec0, input logic ede);
        logic [10:0] e;
        sb_q.push_back({ede, ec1, ec0, ed});
        tmds_word = w;
        tick();
        e = sb_q.pop_front();
        chk(tag, 32'({de, c1, c0, data}), 32'(e));
    endtask

    // Reference DVI transmitter encoder with running disparity.
    task automatic encode(input logic [7:0] d, output logic [9:0] q);
        logic [8:0] qm;
        int n1d, n1, n0;
        n1d = $countones(d);
        qm[0] = d[0];
        if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (enc_cnt == 0 || n1 == n0) begin
            q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            if (qm[8]) enc_cnt = enc_cnt + n1 - n0;
            else       enc_cnt = enc_cnt + n0 - n1;
        end else if ((enc_cnt > 0 && n1 > n0) || (enc_cnt < 0 && n0 > n1)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            enc_cnt = enc_cnt + 2 * int'(qm[8]) + n0 - n1;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            enc_cnt = enc_cnt - 2 * int'(~qm[8]) + n1 - n0;
        end
    endtask

    function automatic logic [9:0] rotr(input logic [9:0] w, input int k);
        logic [19:0] dd;
        dd = {w, w};
        return dd[k +: 10];
    endfunction

    task automatic do_reset();
        reset_n   = 1'b0;
        tmds_word = 10'd0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_slip(input int budget, output int n, output bit found);
        n = 0;
        found = 1'b0;
        while (!found && n < budget) begin
            n++;
            tick();
            if (bitslip === 1'b1) found = 1'b1;
        end
    endtask

    initial begin
        logic [9:0] w;
        int snap, n, off, ns, i, t_al;
        int t_slip[3];
        bit found;

        // ---- reset state ----
        reset_n   = 1'b0;
        tmds_word = 10'd0;
        repeat (3) tick();
        chk("reset_outputs", 32'({bitslip, aligned, slip_count, data, c0, c1, de}), 32'd0);
        reset_n = 1'b1;

        // ---- aligned stream: lock on the 16th token, no slips ----
        snap = slip_seen;
        for (int k = 1; k <= 20; k++) begin
            drive_exp("token00_decode", TOK00, 8'h00, 1'b0, 1'b0, 1'b0);
            if (k == 15) chk("aligned_before_16", 32'(aligned), 32'd0);
            if (k == 16) chk("aligned_at_16", 32'(aligned), 32'd1);
        end
        chk("no_slip_aligned", 32'(slip_seen - snap), 32'd0);

        // ---- directed decode, control tokens, c hold ----
        drive_exp("dec_0100000001", 10'b0100000001, 8'h03, 1'b0, 1'b0, 1'b1);
        drive_exp("dec_1011111111", 10'b1011111111, 8'hFE, 1'b0, 1'b0, 1'b1);
        drive_exp("token01",        TOK01,          8'h00, 1'b0, 1'b1, 1'b0);
        drive_exp("hold_c_01",      DATA0,          8'h00, 1'b0, 1'b1, 1'b1);
        drive_exp("token11",        TOK11,          8'h00, 1'b1, 1'b1, 1'b0);
        drive_exp("dec_1111111111", 10'b1111111111, 8'h00, 1'b1, 1'b1, 1'b1);
        drive_exp("token10",        TOK10,          8'h00, 1'b1, 1'b0, 1'b0);
        drive_exp("dec_1000000000", 10'b1000000000, 8'hFF, 1'b1, 1'b0, 1'b1);

        // ---- all 256 bytes through the reference encoder ----
        enc_cnt = 0;
        for (int b = 0; b < 256; b++) begin
            encode(8'(b), w);
            drive_exp("sweep", w, 8'(b), 1'b1, 1'b0, 1'b1);
        end
        chk("aligned_after_sweep", 32'(aligned), 32'd1);

        // ---- lock loss after 8192 data words ----
        put(TOK00);
        repeat (8191) put(DATA0);
        chk("aligned_after_8191", 32'(aligned), 32'd1);
        put(DATA0);
        chk("aligned_drop_8192", 32'(aligned), 32'd0);

        // ---- relock from SEARCH ----
        snap = slip_seen;
        repeat (15) put(TOK00);
        chk("relock_before_16", 32'(aligned), 32'd0);
        put(TOK00);
        chk("relock_at_16", 32'(aligned), 32'd1);

        // ---- single token restarts loss counter ----
        repeat (7999) put(DATA0);
        put(TOK00);
        repeat (300) put(DATA0);
        chk("lock_held_token_8000", 32'(aligned), 32'd1);
        chk("no_slip_locked", 32'(slip_seen - snap), 32'd0);

        // ---- misalignment: tokens rotated by 3 bits ----
        do_reset();
        snap = slip_seen;
        off = 3;
        ns = 0;
        i = 0;
        t_al = 0;
        while (t_al == 0 && i < 13000) begin
            i++;
            tmds_word = rotr(TOK00, off);
            tick();
            if (bitslip === 1'b1) begin
                if (ns < 3) t_slip[ns] = i;
                ns++;
                if (off > 0) off--;
            end
            if (aligned === 1'b1) t_al = i;
        end
        chk("misalign_slips", 32'(ns), 32'd3);
        chk("slip1_time", 32'(t_slip[0]), 32'd4096);
        chk("slip2_time", 32'(t_slip[1]), 32'd8200);
        chk("slip3_time", 32'(t_slip[2]), 32'd12304);
        chk("slip_width", 32'(slip_seen - snap), 32'd3);
        chk("misalign_lock_time", 32'(t_al), 32'd12328);
        chk("misalign_slip_count", 32'(slip_count), 32'd3);

        // ---- slip wrap: never a token ----
        do_reset();
        tmds_word = DATA0;
        chk("wrap_start_count", 32'(slip_count), 32'd0);
        for (int p = 1; p <= 10; p++) begin
            wait_slip(4200, n, found);
            chk("wrap_pulse_found", 32'(found), 32'd1);
            chk("wrap_interval", 32'(n), (p == 1) ? 32'd4096 : 32'd4104);
            chk("wrap_slip_count", 32'(slip_count), 32'(p % 10));
        end

        // ---- reset asserted during a bitslip pulse ----
        wait_slip(4200, n, found);
        chk("pulse_before_reset", 32'(bitslip), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_status", 32'({bitslip, aligned, slip_count}), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;

        // ---- fresh start after reset ----
        snap = slip_seen;
        repeat (15) put(TOK00);
        chk("fresh_before_16", 32'(aligned), 32'd0);
        put(TOK00);
        chk("fresh_at_16", 32'(aligned), 32'd1);
        chk("fresh_slip_count", 32'(slip_count), 32'd0);
        chk("fresh_no_slip", 32'(slip_seen - snap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
